sdio_data_router: RTL and testbench

Parametrised, registered successor to the SDIO data-path multiplexer. It routes byte streams between one of two host-side sources (command-bus single-byte access or the data PHY) and one of NUM_CH = NUM_FUNCS+2 function-side channels (CIA, functions 1..NUM_FUNCS, memory). It adds latched per-transfer routing, byte counting with automatic completion, abort, and an inactivity timeout. It sits between the command layer / data PHY and the CIA, function and memory blocks.

---
 rtl/sdio_data_router_if.sv | 47 ++++
 rtl/sdio_data_router.sv | 228 ++++++++++++++++++++++
 tb/tb_sdio_data_router.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdio_data_router_if.sv
// SDIO data router bus bundle: command-bus and data-PHY host ports
// plus the per-channel function-side ports.
interface sdio_data_router_if #(
  parameter int NUM_FUNCS  = 7,
  parameter int DATA_WIDTH = 8
);
  localparam int NUM_CH = NUM_FUNCS + 2;

  logic                         i_cmd_wr_stb;
  logic [DATA_WIDTH-1:0]        i_cmd_wr_data;
  logic                         o_cmd_rd_stb;
  logic [DATA_WIDTH-1:0]        o_cmd_rd_data;
  logic                         i_cmd_hst_rdy;
  logic                         o_cmd_com_rdy;

  logic                         i_phy_wr_stb;
  logic [DATA_WIDTH-1:0]        i_phy_wr_data;
  logic                         o_phy_rd_stb;
  logic [DATA_WIDTH-1:0]        o_phy_rd_data;
  logic                         i_phy_hst_rdy;
  logic                         o_phy_com_rdy;

  logic [NUM_CH-1:0]            o_ch_wr_stb;
  logic [NUM_CH*DATA_WIDTH-1:0] o_ch_wr_data;
  logic [NUM_CH-1:0]            o_ch_hst_rdy;
  logic [NUM_CH-1:0]            i_ch_rd_stb;
  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_rd_data;
  logic [NUM_CH-1:0]            i_ch_com_rdy;

  modport slave (
    input  i_cmd_wr_stb, i_cmd_wr_data, i_cmd_hst_rdy,
    output o_cmd_rd_stb, o_cmd_rd_data, o_cmd_com_rdy,
    input  i_phy_wr_stb, i_phy_wr_data, i_phy_hst_rdy,
    output o_phy_rd_stb, o_phy_rd_data, o_phy_com_rdy,
    output o_ch_wr_stb, o_ch_wr_data, o_ch_hst_rdy,
    input  i_ch_rd_stb, i_ch_rd_data, i_ch_com_rdy
  );

  modport master (
    output i_cmd_wr_stb, i_cmd_wr_data, i_cmd_hst_rdy,
    input  o_cmd_rd_stb, o_cmd_rd_data, o_cmd_com_rdy,
    output i_phy_wr_stb, i_phy_wr_data, i_phy_hst_rdy,
    input  o_phy_rd_stb, o_phy_rd_data, o_phy_com_rdy,
    input  o_ch_wr_stb, o_ch_wr_data, o_ch_hst_rdy,
    output i_ch_rd_stb, i_ch_rd_data, i_ch_com_rdy
  );
endinterface

// File: rtl/sdio_data_router.sv
// SDIO data router: latched per-transfer routing between one host
// source and one function-side channel, with counting and timeout.
module sdio_data_router #(
  parameter int NUM_FUNCS      = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [2:0]           i_func_sel,
  input  logic                 i_mem_sel,
  input  logic                 i_cmd_bus_sel,
  input  logic                 i_write,
  input  logic [LEN_WIDTH-1:0] i_xfer_len,
  input  logic                 i_abort,
  sdio_data_router_if.slave    bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic                 o_err,
  output logic [LEN_WIDTH:0]   o_byte_count
);
  localparam int NUM_CH = NUM_FUNCS + 2;
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = LEN_WIDTH + 1;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW > 0) ? TW_RAW : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] MEM_CH = CW'(NUM_FUNCS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic                  cmd_q, cmd_d;
  logic                  wr_q, wr_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [NUM_CH-1:0]     ch_wr_stb_q, ch_wr_stb_d;
  logic [DATA_WIDTH-1:0] ch_wr_data_q [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_wr_data_d [NUM_CH];
  logic [NUM_CH-1:0]     ch_hst_q, ch_hst_d;
  logic                  cmd_rd_stb_q, cmd_rd_stb_d;
  logic [DATA_WIDTH-1:0] cmd_rd_data_q, cmd_rd_data_d;
  logic                  cmd_com_q, cmd_com_d;
  logic                  phy_rd_stb_q, phy_rd_stb_d;
  logic [DATA_WIDTH-1:0] phy_rd_data_q, phy_rd_data_d;
  logic                  phy_com_q, phy_com_d;

  logic [DATA_WIDTH-1:0] rd_arr [NUM_CH];
  logic                  src_stb;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_hst;
  logic                  chn_stb;
  logic [DATA_WIDTH-1:0] chn_data;
  logic                  chn_com;
  logic                  fwd;
  logic [CNT_W-1:0]      cnt_inc;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign rd_arr[k] =
      bus.i_ch_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign bus.o_ch_wr_data[k*DATA_WIDTH +: DATA_WIDTH] =
      ch_wr_data_q[k];
  end

  assign bus.o_ch_wr_stb   = ch_wr_stb_q;
  assign bus.o_ch_hst_rdy  = ch_hst_q;
  assign bus.o_cmd_rd_stb  = cmd_rd_stb_q;
  assign bus.o_cmd_rd_data = cmd_rd_data_q;
  assign bus.o_cmd_com_rdy = cmd_com_q;
  assign bus.o_phy_rd_stb  = phy_rd_stb_q;
  assign bus.o_phy_rd_data = phy_rd_data_q;
  assign bus.o_phy_com_rdy = phy_com_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_timeout    = tmo_q;
  assign o_err        = err_q;
  assign o_byte_count = cnt_q;

  // Views of the latched source and channel, and the accept decision
  always_comb begin
    src_stb  = cmd_q ? bus.i_cmd_wr_stb  : bus.i_phy_wr_stb;
    src_data = cmd_q ? bus.i_cmd_wr_data : bus.i_phy_wr_data;
    src_hst  = cmd_q ? bus.i_cmd_hst_rdy : bus.i_phy_hst_rdy;
    chn_stb  = bus.i_ch_rd_stb[ch_q];
    chn_data = rd_arr[ch_q];
    chn_com  = bus.i_ch_com_rdy[ch_q];
    fwd      = (state_q == ACTIVE) && !i_abort &&
               (wr_q ? src_stb : chn_stb);
    cnt_inc  = cnt_q + 1'b1;
  end

  // Transfer FSM and next value of every routed output
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cmd_d         = cmd_q;
    wr_d          = wr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    done_d        = 1'b0;
    tmo_d         = 1'b0;
    err_d         = 1'b0;
    ch_wr_stb_d   = '0;
    ch_wr_data_d  = '{default: '0};
    ch_hst_d      = '0;
    cmd_rd_stb_d  = 1'b0;
    cmd_rd_data_d = '0;
    cmd_com_d     = 1'b0;
    phy_rd_stb_d  = 1'b0;
    phy_rd_data_d = '0;
    phy_com_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          if (!i_mem_sel && int'(i_func_sel) > NUM_FUNCS) begin
            err_d = 1'b1;
          end else begin
            ch_d  = i_mem_sel ? MEM_CH : CW'(i_func_sel);
            cmd_d = i_cmd_bus_sel;
            wr_d  = i_write;
            if (i_cmd_bus_sel)
              len_d = CNT_W'(1);
            else if (i_xfer_len == '0)
              len_d = CNT_W'(1) << LEN_WIDTH;
            else
              len_d = {1'b0, i_xfer_len};
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          ch_hst_d[ch_q] = src_hst;
          if (cmd_q) cmd_com_d = chn_com;
          else       phy_com_d = chn_com;
          if (fwd) begin
            if (wr_q) begin
              ch_wr_stb_d[ch_q]  = 1'b1;
              ch_wr_data_d[ch_q] = src_data;
            end else if (cmd_q) begin
              cmd_rd_stb_d  = 1'b1;
              cmd_rd_data_d = chn_data;
            end else begin
              phy_rd_stb_d  = 1'b1;
              phy_rd_data_d = chn_data;
            end
            cnt_d = cnt_inc;
            tmr_d = '0;
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else if (TIMEOUT_CYCLES != 0 && tmr_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      cmd_q         <= 1'b0;
      wr_q          <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      tmr_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tmo_q         <= 1'b0;
      err_q         <= 1'b0;
      ch_wr_stb_q   <= '0;
      ch_wr_data_q  <= '{default: '0};
      ch_hst_q      <= '0;
      cmd_rd_stb_q  <= 1'b0;
      cmd_rd_data_q <= '0;
      cmd_com_q     <= 1'b0;
      phy_rd_stb_q  <= 1'b0;
      phy_rd_data_q <= '0;
      phy_com_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cmd_q         <= cmd_d;
      wr_q          <= wr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
      ch_wr_stb_q   <= ch_wr_stb_d;
      ch_wr_data_q  <= ch_wr_data_d;
      ch_hst_q      <= ch_hst_d;
      cmd_rd_stb_q  <= cmd_rd_stb_d;
      cmd_rd_data_q <= cmd_rd_data_d;
      cmd_com_q     <= cmd_com_d;
      phy_rd_stb_q  <= phy_rd_stb_d;
      phy_rd_data_q <= phy_rd_data_d;
      phy_com_q     <= phy_com_d;
    end
  end
endmodule

// File: tb/tb_sdio_data_router.sv
// Bench for sdio_data_router: directed transfers plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_sdio_data_router;
  localparam int NF    = 5;
  localparam int DW    = 8;
  localparam int LW    = 9;
  localparam int TMO   = 16;
  localparam int NCH   = NF + 2;
  localparam int MEMCH = NF + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [2:0]    i_func_sel;
  logic          i_mem_sel;
  logic          i_cmd_bus_sel;
  logic          i_write;
  logic [LW-1:0] i_xfer_len;
  logic          i_abort;
  logic          o_busy, o_done, o_timeout, o_err;
  logic [LW:0]   o_byte_count;

  logic [NCH-1:0][DW-1:0] rd_dat;

  sdio_data_router_if #(.NUM_FUNCS(NF), .DATA_WIDTH(DW)) bus ();

  assign bus.i_ch_rd_data = rd_dat;

  sdio_data_router #(
    .NUM_FUNCS(NF), .DATA_WIDTH(DW),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_func_sel(i_func_sel),
    .i_mem_sel(i_mem_sel), .i_cmd_bus_sel(i_cmd_bus_sel),
    .i_write(i_write), .i_xfer_len(i_xfer_len),
    .i_abort(i_abort), .bus(bus),
    .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout), .o_err(o_err),
    .o_byte_count(o_byte_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one open transaction, described by its target,
  // its length and how many bytes it has moved so far.
  int m_ph;
  int m_ch, m_len, m_cnt, m_idle;
  bit m_cmd, m_wr;

  logic [NCH-1:0]         e_wstb, e_hst;
  logic [NCH-1:0][DW-1:0] e_wdat;
  logic                   e_crs, e_prs, e_ccom, e_pcom;
  logic [DW-1:0]          e_crd, e_prd;
  logic                   e_busy, e_done, e_tmo, e_err;

  task automatic model_step();
    bit stb;
    e_wstb = '0; e_wdat = '0; e_hst = '0;
    e_crs = 0; e_crd = '0; e_ccom = 0;
    e_prs = 0; e_prd = '0; e_pcom = 0;
    e_done = 0; e_tmo = 0; e_err = 0;
    if (rst) begin
      m_ph  = 0;
      m_cnt = 0;
    end else if (m_ph == 2) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (i_start && !i_abort) begin
        if (!i_mem_sel && int'(i_func_sel) > NF) begin
          e_err = 1;
        end else begin
          m_ch  = i_mem_sel ? MEMCH : int'(i_func_sel);
          m_cmd = i_cmd_bus_sel;
          m_wr  = i_write;
          if (i_cmd_bus_sel)     m_len = 1;
          else if (i_xfer_len == 0) m_len = 1 << LW;
          else                   m_len = int'(i_xfer_len);
          m_cnt  = 0;
          m_idle = 0;
          m_ph   = 1;
        end
      end
    end else if (i_abort) begin
      m_ph = 0;
    end else begin
      e_hst[m_ch] = m_cmd ? bus.i_cmd_hst_rdy : bus.i_phy_hst_rdy;
      if (m_cmd) e_ccom = bus.i_ch_com_rdy[m_ch];
      else       e_pcom = bus.i_ch_com_rdy[m_ch];
      if (m_wr) stb = m_cmd ? bus.i_cmd_wr_stb : bus.i_phy_wr_stb;
      else      stb = bus.i_ch_rd_stb[m_ch];
      if (stb) begin
        if (m_wr) begin
          e_wstb[m_ch] = 1'b1;
          e_wdat[m_ch] = m_cmd ? bus.i_cmd_wr_data : bus.i_phy_wr_data;
        end else if (m_cmd) begin
          e_crs = 1; e_crd = rd_dat[m_ch];
        end else begin
          e_prs = 1; e_prd = rd_dat[m_ch];
        end
        m_cnt++;
        m_idle = 0;
        if (m_cnt == m_len) begin
          e_done = 1;
          m_ph   = 2;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          e_tmo = 1;
          m_ph  = 0;
        end
      end
    end
    e_busy = (m_ph != 0);
  endtask

  task automatic compare();
    check("wstb", bus.o_ch_wr_stb, e_wstb);
    check("wdat", bus.o_ch_wr_data, e_wdat);
    check("hst", bus.o_ch_hst_rdy, e_hst);
    check("cmdrd", {bus.o_cmd_rd_stb, bus.o_cmd_rd_data,
                    bus.o_cmd_com_rdy}, {e_crs, e_crd, e_ccom});
    check("phyrd", {bus.o_phy_rd_stb, bus.o_phy_rd_data,
                    bus.o_phy_com_rdy}, {e_prs, e_prd, e_pcom});
    check("flags", {o_busy, o_done, o_timeout, o_err},
          {e_busy, e_done, e_tmo, e_err});
    check("count", o_byte_count, m_cnt[LW:0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    i_start = 0; i_func_sel = '0; i_mem_sel = 0;
    i_cmd_bus_sel = 0; i_write = 0; i_xfer_len = '0; i_abort = 0;
    bus.i_cmd_wr_stb = 0; bus.i_cmd_wr_data = '0;
    bus.i_cmd_hst_rdy = 0;
    bus.i_phy_wr_stb = 0; bus.i_phy_wr_data = '0;
    bus.i_phy_hst_rdy = 0;
    bus.i_ch_rd_stb = '0; bus.i_ch_com_rdy = '0;
    rd_dat = '0;
  endtask

  task automatic noise(int p);
    for (int k = 0; k < NCH; k++) begin
      bus.i_ch_rd_stb[k] = ($urandom_range(99) < p);
      rd_dat[k] = DW'($urandom);
    end
    bus.i_ch_com_rdy  = NCH'($urandom);
    bus.i_cmd_hst_rdy = 1'($urandom);
    bus.i_phy_hst_rdy = 1'($urandom);
    bus.i_cmd_wr_stb  = ($urandom_range(99) < p);
    bus.i_phy_wr_stb  = ($urandom_range(99) < p);
    bus.i_cmd_wr_data = DW'($urandom);
    bus.i_phy_wr_data = DW'($urandom);
    i_func_sel    = 3'($urandom);
    i_mem_sel     = ($urandom_range(5) == 0);
    i_cmd_bus_sel = 1'($urandom);
    i_write       = 1'($urandom);
    i_xfer_len    = ($urandom_range(19) == 0) ? '0 :
                    LW'($urandom_range(6, 1));
    i_start = ($urandom_range(3) == 0);
    i_abort = ($urandom_range(199) == 0);
    rst     = ($urandom_range(799) == 0);
  endtask

  task automatic start(bit cmd, bit wr, bit mem, int fn, int len);
    quiet();
    i_start = 1; i_cmd_bus_sel = cmd; i_write = wr;
    i_mem_sel = mem; i_func_sel = 3'(fn); i_xfer_len = LW'(len);
    tick();
    quiet();
  endtask

  initial begin
    int plist[4];
    plist = '{90, 50, 10, 2};
    m_ph = 0; m_cnt = 0; m_idle = 0; m_len = 1;
    m_ch = 0; m_cmd = 0; m_wr = 0;
    quiet();
    rst = 1;
    tick(); tick();
    rst = 0;
    repeat (10) tick();
    check("idle_busy", o_busy, 0);
    check("idle_cnt", o_byte_count, 0);

    // PHY write to function 3, four bytes back to back
    start(0, 1, 0, 3, 4);
    check("w_busy", o_busy, 1);
    for (int b = 0; b < 4; b++) begin
      bus.i_phy_wr_stb = 1;
      bus.i_phy_wr_data = DW'(8'hA1 + b);
      i_func_sel = 3'd5;
      tick();
      check("w_stb", bus.o_ch_wr_stb, 7'b0001000);
      check("w_dat", bus.o_ch_wr_data[3*DW +: DW], 8'hA1 + b);
    end
    check("w_done", o_done, 1);
    check("w_cnt", o_byte_count, 4);
    quiet();
    tick();
    check("w_idle", o_busy, 0);

    // Command-bus read from memory, length forced to one
    start(1, 0, 1, 0, 9);
    bus.i_ch_rd_stb[MEMCH] = 1;
    rd_dat[MEMCH] = 8'h5C;
    tick();
    check("c_stb", {bus.o_cmd_rd_stb, bus.o_cmd_rd_data}, 9'h15C);
    check("c_done", o_done, 1);
    tick();
    check("c_drop", bus.o_cmd_rd_stb, 0);
    quiet();
    tick();

    // Start to a function that does not exist
    start(0, 1, 0, 6, 2);
    check("e_err", {o_err, o_busy}, 2'b10);
    tick();
    check("e_clr", {o_err, o_busy}, 2'b00);

    // Long PHY read aborted after 100 bytes
    start(0, 0, 0, 1, 0);
    for (int b = 0; b < 100; b++) begin
      bus.i_ch_rd_stb[1] = 1;
      rd_dat[1] = DW'($urandom);
      tick();
    end
    i_abort = 1;
    tick();
    check("a_flags", {o_busy, o_done, bus.o_phy_rd_stb}, 3'b000);
    check("a_cnt", o_byte_count, 100);
    quiet();
    tick();

    // One byte then stall until the timeout fires
    start(0, 1, 0, 2, 3);
    bus.i_phy_wr_stb = 1;
    bus.i_phy_wr_data = 8'h3E;
    tick();
    quiet();
    for (int c = 1; c < TMO; c++) begin
      tick();
      check("t_wait", {o_busy, o_timeout}, 2'b10);
    end
    tick();
    check("t_fire", {o_busy, o_timeout}, 2'b01);
    check("t_cnt", o_byte_count, 1);
    tick();

    // Reset in the middle of a transfer drops the pending strobe
    start(0, 1, 0, 0, 5);
    bus.i_phy_wr_stb = 1;
    bus.i_phy_wr_data = 8'h77;
    rst = 1;
    tick();
    check("r_stb", bus.o_ch_wr_stb, 0);
    check("r_flags", {o_busy, o_byte_count}, 0);
    rst = 0;
    quiet();
    tick();

    for (int blk = 0; blk < 150; blk++) begin
      int p;
      p = plist[$urandom_range(3)];
      repeat (100) begin
        noise(p);
        tick();
      end
    end
    rst = 0;
    quiet();
    repeat (20) tick();
    check("end_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
